// File: rtl/fpga_ram_tcdm_adapter.sv
// TCDM request/grant master port to a single FPGA block-RAM bank.
// Credit-based grant plus a response FIFO let the master apply r_ready backpressure without losing responses.
module fpga_ram_tcdm_adapter #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [31:0]           r_rdata_o,
    output logic                  r_opc_o,
    output logic                  ram_csn_o,
    output logic                  ram_wen_o,
    output logic [3:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [CNT_W-1:0]       outstanding_q;
    logic [CNT_W-1:0]       fifo_cnt_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [RAM_LATENCY-1:0] pipe_vld_q;
    logic [RAM_LATENCY-1:0] pipe_opc_q;
    logic [31:0]            fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_opc_q;

    logic pop;
    logic push;
    logic push_opc;
    logic credit_ok;
    logic fifo_full;
    logic unused_add;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_add = ^{add_i[31:ADDR_WIDTH+2], add_i[1:0]};

    // Grant while a FIFO slot is reserved for every outstanding access, or one frees this cycle.
    // Gating with rst_ni keeps the bank idle for the whole reset window.
    assign r_valid_o = (fifo_cnt_q != '0);
    assign pop       = r_valid_o & r_ready_i;
    assign credit_ok = (outstanding_q < CNT_W'(FIFO_DEPTH)) | pop;
    assign gnt_o     = rst_ni & req_i & credit_ok;
    assign fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));

    assign ram_csn_o   = ~gnt_o;
    assign ram_wen_o   = gnt_o & wen_i;
    assign ram_be_o    = (gnt_o & wen_i) ? be_i : 4'b0000;
    assign ram_addr_o  = gnt_o ? add_i[ADDR_WIDTH+1:2] : '0;
    assign ram_wdata_o = gnt_o ? wdata_i : 32'h0;

    assign push     = pipe_vld_q[RAM_LATENCY-1];
    assign push_opc = pipe_opc_q[RAM_LATENCY-1];

    assign r_rdata_o = fifo_data_q[rd_ptr_q];
    assign r_opc_o   = fifo_opc_q[rd_ptr_q];

    // Credit counter: granted but not yet popped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else if (gnt_o && !pop) begin
            outstanding_q <= outstanding_q + CNT_W'(1);
        end else if (!gnt_o && pop) begin
            outstanding_q <= outstanding_q - CNT_W'(1);
        end
    end

    // Valid/opc shift register aligned with the bank read latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q <= '0;
            pipe_opc_q <= '0;
        end else begin
            pipe_vld_q <= RAM_LATENCY'({pipe_vld_q, gnt_o});
            pipe_opc_q <= RAM_LATENCY'({pipe_opc_q, gnt_o & wen_i});
        end
    end

    // Response FIFO; write responses carry zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            fifo_opc_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= 32'h0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= push_opc ? 32'h0 : ram_rdata_i;
                fifo_opc_q[wr_ptr_q]  <= push_opc;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: tb/tb_fpga_ram_tcdm_adapter.sv
// Directed bench: two adapter instances (latency 1/depth 2 and latency 2/depth 3) against behavioural RAM banks.
module tb_fpga_ram_tcdm_adapter;

    logic clk = 1'b0;
    logic rst_n;
    logic init_mem;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic        req1, gnt1, wen1, rv1, rr1, opc1, csn1, rwen1;
    logic [31:0] add1, wdata1, rdata1, rwdata1, rrd1;
    logic [3:0]  be1, rbe1;
    logic [11:0] raddr1;

    logic        req2, gnt2, wen2, rv2, rr2, opc2, csn2, rwen2;
    logic [31:0] add2, wdata2, rdata2, rwdata2, rrd2a, rrd2b;
    logic [3:0]  be2, rbe2;
    logic [11:0] raddr2;

    logic [31:0] mem1 [4096];
    logic [31:0] mem2 [4096];

    fpga_ram_tcdm_adapter #(.ADDR_WIDTH(12), .RAM_LATENCY(1), .FIFO_DEPTH(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .gnt_o(gnt1), .add_i(add1), .wen_i(wen1),
        .be_i(be1), .wdata_i(wdata1), .r_valid_o(rv1), .r_ready_i(rr1), .r_rdata_o(rdata1),
        .r_opc_o(opc1), .ram_csn_o(csn1), .ram_wen_o(rwen1), .ram_be_o(rbe1), .ram_addr_o(raddr1),
        .ram_wdata_o(rwdata1), .ram_rdata_i(rrd1)
    );

    fpga_ram_tcdm_adapter #(.ADDR_WIDTH(12), .RAM_LATENCY(2), .FIFO_DEPTH(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .add_i(add2), .wen_i(wen2),
        .be_i(be2), .wdata_i(wdata2), .r_valid_o(rv2), .r_ready_i(rr2), .r_rdata_o(rdata2),
        .r_opc_o(opc2), .ram_csn_o(csn2), .ram_wen_o(rwen2), .ram_be_o(rbe2), .ram_addr_o(raddr2),
        .ram_wdata_o(rwdata2), .ram_rdata_i(rrd2b)
    );

    // Behavioural banks: bank 1 has one cycle of read latency, bank 2 has two.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) begin
                mem1[i] <= 32'hC000_0000 | 32'(i);
                mem2[i] <= 32'hC000_0000 | 32'(i);
            end
            mem1[16] <= 32'hDEAD_BEEF;
            mem1[32] <= 32'hFFFF_FFFF;
        end else begin
            if (!csn1) begin
                if (rwen1) begin
                    for (int b = 0; b < 4; b++) begin
                        if (rbe1[b]) mem1[raddr1][8*b +: 8] <= rwdata1[8*b +: 8];
                    end
                end
                rrd1 <= mem1[raddr1];
            end
            if (!csn2) rrd2a <= mem2[raddr2];
            rrd2b <= rrd2a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t_add   [4] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_0084, 32'hFFFF_C040};
    logic        t_wen   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  t_be    [4] = '{4'b0011, 4'b1111, 4'b0000, 4'b1111};
    logic [31:0] t_wdata [4] = '{32'h1234_5678, 32'h0, 32'hAAAA_AAAA, 32'h0};
    logic [3:0]  e_be    [4] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] e_addr  [4] = '{32'h20, 32'h20, 32'h21, 32'h10};
    logic [31:0] e_opc   [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
    logic [31:0] e_rdata [4] = '{32'h0, 32'hFFFF_5678, 32'h0, 32'hDEAD_BEEF};

    initial begin
        int nk;
        rst_n = 1'b0; init_mem = 1'b1;
        req1 = 1'b1; add1 = 32'h40; wen1 = 1'b0; be1 = 4'h0; wdata1 = 32'h0; rr1 = 1'b1;
        req2 = 1'b0; add2 = 32'h0;  wen2 = 1'b0; be2 = 4'h0; wdata2 = 32'h0; rr2 = 1'b1;

        // Reset values, with a request pending on instance 1.
        @(negedge clk);
        chk("rst_gnt", 32'(gnt1), 32'd0);
        chk("rst_csn", 32'(csn1), 32'd1);
        chk("rst_ram_wen", 32'(rwen1), 32'd0);
        chk("rst_rvalid", 32'(rv1), 32'd0);
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_opc", 32'(opc1), 32'd0);
        chk("rst_rvalid2", 32'(rv2), 32'd0);
        chk("rst_csn2", 32'(csn2), 32'd1);
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single read of word 0x10.
        next_cycle(); req1 = 1'b1; add1 = 32'h40; wen1 = 1'b0;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt1), 32'd1);
        chk("rd_csn", 32'(csn1), 32'd0);
        chk("rd_addr", 32'(raddr1), 32'h10);
        chk("rd_rvalid_t0", 32'(rv1), 32'd0);
        next_cycle(); req1 = 1'b0;
        @(negedge clk);
        chk("rd_rvalid_t1", 32'(rv1), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rd_rvalid_t2", 32'(rv1), 32'd1);
        chk("rd_rdata", rdata1, 32'hDEAD_BEEF);
        chk("rd_opc", 32'(opc1), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rd_rvalid_t3", 32'(rv1), 32'd0);

        // Streaming 10 reads of words 0x100.. with r_ready high.
        for (int c = 0; c < 13; c++) begin
            next_cycle(); req1 = (c < 10); add1 = 32'h400 + 32'(4 * c); rr1 = 1'b1;
            @(negedge clk);
            chk("stream_gnt", 32'(gnt1), 32'(c < 10));
            chk("stream_rvalid", 32'(rv1), 32'(c >= 2 && c < 12));
            if (c >= 2 && c < 12) chk("stream_rdata", rdata1, 32'hC000_0100 + 32'(c - 2));
        end

        // Backpressure: two credits only, then one grant per pop.
        nk = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); req1 = 1'b1; add1 = 32'h800 + 32'(4 * nk); rr1 = 1'b0;
            @(negedge clk);
            chk("bp_gnt_hold", 32'(gnt1), 32'(c < 2));
            if (c >= 2) chk("bp_head_stable", rdata1, 32'hC000_0200);
            if (c < 2) nk++;
        end
        for (int b = 0; b < 7; b++) begin
            next_cycle(); req1 = (b < 4); add1 = 32'h800 + 32'(4 * nk); rr1 = 1'b1;
            @(negedge clk);
            chk("bp_gnt_pop", 32'(gnt1), 32'(b < 4));
            chk("bp_rvalid", 32'(rv1), 32'(b < 6));
            if (b < 6) chk("bp_rdata", rdata1, 32'hC000_0200 + 32'(b));
            if (b < 4) nk++;
        end

        // Partial write, read-back, be=0 write, high-address-bit read.
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            req1 = (c < 4);
            if (c < 4) begin
                add1 = t_add[c]; wen1 = t_wen[c]; be1 = t_be[c]; wdata1 = t_wdata[c];
            end
            @(negedge clk);
            if (c < 4) begin
                chk("wr_gnt", 32'(gnt1), 32'd1);
                chk("wr_ram_wen", 32'(rwen1), 32'(t_wen[c]));
                chk("wr_ram_be", 32'(rbe1), 32'(e_be[c]));
                chk("wr_ram_addr", 32'(raddr1), e_addr[c]);
            end
            if (c >= 2) begin
                chk("wr_rvalid", 32'(rv1), 32'd1);
                chk("wr_opc", 32'(opc1), e_opc[c-2]);
                chk("wr_rdata", rdata1, e_rdata[c-2]);
            end
        end
        wen1 = 1'b0; be1 = 4'h0;

        // Latency 2 / depth 3: eight reads streamed.
        for (int c = 0; c < 12; c++) begin
            next_cycle(); req2 = (c < 8); add2 = 32'hC00 + 32'(4 * c);
            @(negedge clk);
            chk("l2_gnt", 32'(gnt2), 32'(c < 8));
            chk("l2_rvalid", 32'(rv2), 32'(c >= 3 && c < 11));
            if (c >= 3 && c < 11) chk("l2_rdata", rdata2, 32'hC000_0300 + 32'(c - 3));
        end

        // Reset while two responses are queued and a grant is live.
        next_cycle(); req1 = 1'b1; add1 = 32'h40; rr1 = 1'b0;
        @(negedge clk); chk("mr_gnt0", 32'(gnt1), 32'd1);
        next_cycle(); add1 = 32'h44;
        @(negedge clk); chk("mr_gnt1", 32'(gnt1), 32'd1);
        next_cycle(); req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mr_queued", 32'(rv1), 32'd1);
        rr1 = 1'b1; req1 = 1'b1; add1 = 32'h48;
        #1;
        chk("mr_pre_csn", 32'(csn1), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid", 32'(rv1), 32'd0);
        chk("mr_csn", 32'(csn1), 32'd1);
        chk("mr_gnt", 32'(gnt1), 32'd0);
        chk("mr_outstanding", 32'(u_dut1.outstanding_q), 32'd0);
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle(); req1 = 1'b1; add1 = 32'h40;
        @(negedge clk); chk("post_gnt", 32'(gnt1), 32'd1);
        next_cycle(); req1 = 1'b0;
        @(negedge clk); chk("post_rvalid_t1", 32'(rv1), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rvalid_t2", 32'(rv1), 32'd1);
        chk("post_rdata", rdata1, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk); chk("post_rvalid_t3", 32'(rv1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
